dag_circ: RTL and testbench
===========================

Name: dag_circ

Overview:
- Parametrised data address generator (DAG) with circular buffering.
- Holds two banks of index (I), modify (M), length (L) and base (B) registers: bank 0 drives data-memory (DM) addresses, bank 1 drives program-memory (PM) addresses.
- Emits a registered address each access. Supports pre-modify and post-modify addressing, with modulo wrap of I inside [B, B+L).
- Sits between the instruction decoder (ps_* control) and the memory address buses. Register read/write goes through the bus-connect data path (bc_dt / dg_bc_dt).

Parameters:
- DW, 16, data/address width
- NREG, 8, I/M/L/B registers per bank (power of 2, ≥2)
- IW, $clog2(NREG), index field width (derived)
- RAW, IW+3, register address width (derived)

Ports:
- clk_exe  in  1  execute clock
- rst  in  1  synchronous active-high reset
- ps_dg_en  in  1  address generation request this cycle
- ps_dg_dgsclt  in  1  bank select: 0 = DM, 1 = PM
- ps_dg_pre  in  1  1 = pre-modify (no I update), 0 = post-modify
- ps_dg_iadd  in  IW  I register index
- ps_dg_madd  in  IW  M register index
- ps_dg_brev  in  1  bit-reverse request (see Optional Feature)
- ps_dg_wrt_en  in  1  register write strobe
- ps_dg_wrt_add  in  RAW  write address {type[1:0], bank, idx}; type 00=I, 01=M, 10=L, 11=B
- ps_dg_rd_add  in  RAW  read address, same encoding
- bc_dt  in  DW  write data
- dg_bc_dt  out  DW  read data, combinational
- dg_dm_add  out  DW  DM address, registered
- dg_dm_vld  out  1  dg_dm_add valid
- dg_ps_add  out  DW  PM address, registered
- dg_ps_vld  out  1  dg_ps_add valid

Behaviour:
- Reset (sync, rst=1 at clk_exe edge):
  - All I/M/L/B registers = 0.
  - dg_dm_add = dg_ps_add = 0; dg_dm_vld = dg_ps_vld = 0.
  - rst overrides any same-cycle write or access.
- Operand values, for bank b = ps_dg_dgsclt:
  - Iv = I[b][iadd], Mv = M[b][madd], Lv = L[b][iadd], Bv = B[b][iadd].
  - Each operand is bypassed: if a same-cycle write targets that register, use bc_dt instead.
- Arithmetic:
  - Mv is signed two's complement. Sum S = Iv + sext(Mv), computed in DW+2 bits.
  - If Lv == 0: linear, N = S mod 2^DW.
  - If Lv != 0: if S ≥ Bv+Lv then N = S−Lv; else if S < Bv then N = S+Lv; else N = S.
  - Wrap is guaranteed only for |Mv| ≤ Lv. Larger |Mv| gives a single correction only; no error is flagged.
- Address output, on each clk_exe edge with ps_dg_en=1:
  - Address A = N if pre-modify, Iv if post-modify.
  - bank 0: dg_dm_add ← A, dg_dm_vld ← 1; dg_ps_vld ← 0.
  - bank 1: dg_ps_add ← A, dg_ps_vld ← 1; dg_dm_vld ← 0.
  - Latency is exactly 1 cycle.
  - With ps_dg_en=0, both vld flags ← 0 and the address registers hold their values.
- I update: post-modify writes I[b][iadd] ← N at the same edge. Pre-modify leaves I unchanged.
- Register write (ps_dg_wrt_en):
  - Target register ← bc_dt at the edge.
  - Writing B[b][k] also loads I[b][k] ← bc_dt (buffer start).
- Collision on the same I register (post-modify update vs. explicit I write or B-induced load): the explicit write wins.
- Read: dg_bc_dt = register at ps_dg_rd_add. If ps_dg_wrt_en and wrt_add == rd_add, dg_bc_dt = bc_dt (write-through).
- No stall or backpressure: one access per cycle, continuously.

Optional Feature:
- Macro DAG_BITREV_EN.
- Defined: when ps_dg_brev=1 on a post-modify access, the emitted address A is Iv with all DW bits reversed. The I update still uses normal or circular N.
- Not defined: ps_dg_brev is ignored and never reverses the address. The port stays present for pin compatibility.

Test Plan:
- Reset, then read every I/M/L/B → all 0. Confirm dg_*_vld = 0.
- Linear post-modify: write I0=0x0100, M1=0x0004 (bank 0). Three accesses, iadd=0, madd=1 → dg_dm_add = 0x0100, 0x0104, 0x0108 on successive cycles; I0 = 0x010C.
- Circular:
  - Bank 1: write B2=0x0200 (which also sets I2=0x0200), L2=5, M3=2. Accesses → dg_ps_add = 0x200, 0x202, 0x204, 0x201, 0x203.
  - Then M3=0xFFFD (−3), from I2=0x0200 → address 0x200, next I2 = 0x202.
- Pre-modify: I0=0x0010, M0=0xFFFF, pre=1 → dg_dm_add = 0x000F; I0 stays 0x0010.
- Bypass/collision: in the same cycle, write I0=0x0050 and request a post-modify access on I0 with M=1 → address 0x0050; I0 = 0x0050 (write wins). Read of I0 in that cycle returns 0x0050.
- Bit-reverse, DW=16, DAG_BITREV_EN defined: I0=0x0001, brev=1 → dg_dm_add = 0x8000. With the macro undefined, same stimulus → 0x0001.

Source files
------------

// File: rtl/dag_circ_if.sv
// Decoder / bus-connect side signal bundle of the circular data address generator.
// The DAG takes the slave modport; the instruction decoder side takes master.
interface dag_circ_if #(
  parameter int unsigned DW   = 16,
  parameter int unsigned NREG = 8
) ();
  localparam int unsigned IW  = $clog2(NREG);
  localparam int unsigned RAW = IW + 3;

  logic           ps_dg_en;
  logic           ps_dg_dgsclt;
  logic           ps_dg_pre;
  logic [IW-1:0]  ps_dg_iadd;
  logic [IW-1:0]  ps_dg_madd;
  logic           ps_dg_brev;
  logic           ps_dg_wrt_en;
  logic [RAW-1:0] ps_dg_wrt_add;
  logic [RAW-1:0] ps_dg_rd_add;
  logic [DW-1:0]  bc_dt;
  logic [DW-1:0]  dg_bc_dt;
  logic [DW-1:0]  dg_dm_add;
  logic           dg_dm_vld;
  logic [DW-1:0]  dg_ps_add;
  logic           dg_ps_vld;

  modport master (
    output ps_dg_en, ps_dg_dgsclt, ps_dg_pre, ps_dg_iadd, ps_dg_madd, ps_dg_brev,
    output ps_dg_wrt_en, ps_dg_wrt_add, ps_dg_rd_add, bc_dt,
    input  dg_bc_dt, dg_dm_add, dg_dm_vld, dg_ps_add, dg_ps_vld
  );

  modport slave (
    input  ps_dg_en, ps_dg_dgsclt, ps_dg_pre, ps_dg_iadd, ps_dg_madd, ps_dg_brev,
    input  ps_dg_wrt_en, ps_dg_wrt_add, ps_dg_rd_add, bc_dt,
    output dg_bc_dt, dg_dm_add, dg_dm_vld, dg_ps_add, dg_ps_vld
  );
endinterface

// File: rtl/dag_circ.sv
// Data address generator with two I/M/L/B banks (DM, PM) and circular buffer wrap.
// Optional bit-reversed post-modify addressing is enabled by defining DAG_BITREV_EN.
module dag_circ #(
  parameter int unsigned DW   = 16,
  parameter int unsigned NREG = 8
) (
  input  logic      clk_exe,
  input  logic      rst,
  dag_circ_if.slave bus
);
  localparam int unsigned IW  = $clog2(NREG);
  localparam int unsigned RAW = IW + 3;
  localparam int unsigned SW  = DW + 2;

  typedef enum logic [1:0] {
    RegI = 2'b00,
    RegM = 2'b01,
    RegL = 2'b10,
    RegB = 2'b11
  } reg_type_e;

  logic [DW-1:0] i_q [2][NREG];
  logic [DW-1:0] i_d [2][NREG];
  logic [DW-1:0] m_q [2][NREG];
  logic [DW-1:0] m_d [2][NREG];
  logic [DW-1:0] l_q [2][NREG];
  logic [DW-1:0] l_d [2][NREG];
  logic [DW-1:0] b_q [2][NREG];
  logic [DW-1:0] b_d [2][NREG];

  logic [DW-1:0] dm_add_q, dm_add_d;
  logic [DW-1:0] ps_add_q, ps_add_d;
  logic          dm_vld_q, dm_vld_d;
  logic          ps_vld_q, ps_vld_d;

  // Register address decode: {type[1:0], bank, idx}
  reg_type_e     wr_type, rd_type;
  logic          wr_bank, rd_bank;
  logic [IW-1:0] wr_idx, rd_idx;

  assign wr_type = reg_type_e'(bus.ps_dg_wrt_add[RAW-1 -: 2]);
  assign wr_bank = bus.ps_dg_wrt_add[IW];
  assign wr_idx  = bus.ps_dg_wrt_add[IW-1:0];
  assign rd_type = reg_type_e'(bus.ps_dg_rd_add[RAW-1 -: 2]);
  assign rd_bank = bus.ps_dg_rd_add[IW];
  assign rd_idx  = bus.ps_dg_rd_add[IW-1:0];

  logic          bank;
  logic [IW-1:0] iadd, madd;

  assign bank = bus.ps_dg_dgsclt;
  assign iadd = bus.ps_dg_iadd;
  assign madd = bus.ps_dg_madd;

  // Same-cycle write hits on the operands of this access
  logic hit_i, hit_m, hit_l, hit_b;

  always_comb begin
    hit_i = bus.ps_dg_wrt_en && (wr_type == RegI) && (wr_bank == bank) && (wr_idx == iadd);
    hit_m = bus.ps_dg_wrt_en && (wr_type == RegM) && (wr_bank == bank) && (wr_idx == madd);
    hit_l = bus.ps_dg_wrt_en && (wr_type == RegL) && (wr_bank == bank) && (wr_idx == iadd);
    hit_b = bus.ps_dg_wrt_en && (wr_type == RegB) && (wr_bank == bank) && (wr_idx == iadd);
  end

  logic [DW-1:0] iv, mv, lv, bv;

  always_comb begin
    iv = hit_i ? bus.bc_dt : i_q[bank][iadd];
    mv = hit_m ? bus.bc_dt : m_q[bank][madd];
    lv = hit_l ? bus.bc_dt : l_q[bank][iadd];
    bv = hit_b ? bus.bc_dt : b_q[bank][iadd];
  end

  // Two guard bits keep I + sext(M) and B + L exact so the wrap compares are signed-safe.
  logic signed [SW-1:0] sum_s, bv_s, lv_s, top_s, nxt_s;
  logic [1:0]           nxt_unused;
  logic [DW-1:0]        n_val;

  always_comb begin
    sum_s = $signed({2'b00, iv}) + $signed({{2{mv[DW-1]}}, mv});
    bv_s  = $signed({2'b00, bv});
    lv_s  = $signed({2'b00, lv});
    top_s = bv_s + lv_s;
    nxt_s = sum_s;
    if (lv != '0) begin
      if (sum_s >= top_s) begin
        nxt_s = sum_s - lv_s;
      end else if (sum_s < bv_s) begin
        nxt_s = sum_s + lv_s;
      end
    end
  end

  assign {nxt_unused, n_val} = nxt_s;

  logic [DW-1:0] addr;

`ifdef DAG_BITREV_EN
  logic [DW-1:0] iv_rev;

  always_comb begin
    iv_rev = '0;
    for (int k = 0; k < DW; k++) begin
      iv_rev[k] = iv[DW-1-k];
    end
  end

  always_comb begin
    addr = bus.ps_dg_pre ? n_val : iv;
    if (bus.ps_dg_brev && !bus.ps_dg_pre) begin
      addr = iv_rev;
    end
  end
`else
  // Pin kept for compatibility; has no effect in this build.
  logic brev_unused;
  assign brev_unused = bus.ps_dg_brev;

  always_comb begin
    addr = bus.ps_dg_pre ? n_val : iv;
  end
`endif

  // Register file next state: post-modify update first so an explicit write overrides it.
  always_comb begin
    i_d = i_q;
    m_d = m_q;
    l_d = l_q;
    b_d = b_q;
    if (bus.ps_dg_en && !bus.ps_dg_pre) begin
      i_d[bank][iadd] = n_val;
    end
    if (bus.ps_dg_wrt_en) begin
      unique case (wr_type)
        RegI: i_d[wr_bank][wr_idx] = bus.bc_dt;
        RegM: m_d[wr_bank][wr_idx] = bus.bc_dt;
        RegL: l_d[wr_bank][wr_idx] = bus.bc_dt;
        RegB: begin
          b_d[wr_bank][wr_idx] = bus.bc_dt;
          i_d[wr_bank][wr_idx] = bus.bc_dt;
        end
      endcase
    end
  end

  always_comb begin
    dm_add_d = dm_add_q;
    ps_add_d = ps_add_q;
    dm_vld_d = 1'b0;
    ps_vld_d = 1'b0;
    if (bus.ps_dg_en) begin
      if (bank) begin
        ps_add_d = addr;
        ps_vld_d = 1'b1;
      end else begin
        dm_add_d = addr;
        dm_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_exe) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < NREG; k++) begin
          i_q[b][k] <= '0;
          m_q[b][k] <= '0;
          l_q[b][k] <= '0;
          b_q[b][k] <= '0;
        end
      end
      dm_add_q <= '0;
      ps_add_q <= '0;
      dm_vld_q <= 1'b0;
      ps_vld_q <= 1'b0;
    end else begin
      i_q      <= i_d;
      m_q      <= m_d;
      l_q      <= l_d;
      b_q      <= b_d;
      dm_add_q <= dm_add_d;
      ps_add_q <= ps_add_d;
      dm_vld_q <= dm_vld_d;
      ps_vld_q <= ps_vld_d;
    end
  end

  logic [DW-1:0] rd_val;

  always_comb begin
    rd_val = '0;
    unique case (rd_type)
      RegI: rd_val = i_q[rd_bank][rd_idx];
      RegM: rd_val = m_q[rd_bank][rd_idx];
      RegL: rd_val = l_q[rd_bank][rd_idx];
      RegB: rd_val = b_q[rd_bank][rd_idx];
    endcase
    if (bus.ps_dg_wrt_en && (bus.ps_dg_wrt_add == bus.ps_dg_rd_add)) begin
      rd_val = bus.bc_dt;
    end
  end

  assign bus.dg_bc_dt  = rd_val;
  assign bus.dg_dm_add = dm_add_q;
  assign bus.dg_dm_vld = dm_vld_q;
  assign bus.dg_ps_add = ps_add_q;
  assign bus.dg_ps_vld = ps_vld_q;

endmodule

// File: tb/tb_dag_circ.sv
// Self-checking bench for dag_circ: array-based register model plus literal anchors.
// Expected bit-reverse result follows DAG_BITREV_EN.
module tb_dag_circ;
  localparam int unsigned DW   = 16;
  localparam int unsigned NREG = 8;
  localparam int unsigned IW   = 3;
  localparam int unsigned RAW  = 6;

`ifdef DAG_BITREV_EN
  localparam logic [15:0] BrevExp = 16'h8000;
`else
  localparam logic [15:0] BrevExp = 16'h0001;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dag_circ_if #(.DW(DW), .NREG(NREG)) bus ();

  dag_circ #(.DW(DW), .NREG(NREG)) dut (
    .clk_exe (clk),
    .rst     (rst),
    .bus     (bus)
  );

  // Model state: plain integers per register
  int mi [2][NREG];
  int mm [2][NREG];
  int ml [2][NREG];
  int mb [2][NREG];

  logic [15:0] e_dm_add = '0;
  logic [15:0] e_ps_add = '0;
  logic        e_dm_vld = 1'b0;
  logic        e_ps_vld = 1'b0;
  logic [15:0] e_rd     = '0;
  bit          chk_en   = 1'b0;

  bit          la_on = 1'b0;
  bit          la_ps = 1'b0;
  logic [15:0] la_val = '0;
  string       la_name = "";
  bit          lr_on = 1'b0;
  logic [15:0] lr_val = '0;
  string       lr_name = "";

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] circ_exp [5] = '{16'h0200, 16'h0202, 16'h0204, 16'h0201, 16'h0203};

  function automatic logic [RAW-1:0] ra(int t, int b, int k);
    return RAW'(t * 16 + b * 8 + k);
  endfunction

  function automatic int model_rd(logic [RAW-1:0] a);
    int t, b, k;
    t = int'(a[5:4]);
    b = int'(a[3]);
    k = int'(a[2:0]);
    if (t == 0) return mi[b][k];
    if (t == 1) return mm[b][k];
    if (t == 2) return ml[b][k];
    return mb[b][k];
  endfunction

  function automatic int bitrev16(int v);
    int r;
    r = 0;
    for (int k = 0; k < 16; k++) begin
      if (((v >> k) & 1) != 0) r = r | (1 << (15 - k));
    end
    return r;
  endfunction

  task automatic cmp(string name, logic [15:0] got, logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("dm_vld", 16'(bus.dg_dm_vld), 16'(e_dm_vld));
      cmp("ps_vld", 16'(bus.dg_ps_vld), 16'(e_ps_vld));
      cmp("dm_add", bus.dg_dm_add, e_dm_add);
      cmp("ps_add", bus.dg_ps_add, e_ps_add);
      cmp("rd_dt", bus.dg_bc_dt, e_rd);
      if (la_on) cmp(la_name, la_ps ? bus.dg_ps_add : bus.dg_dm_add, la_val);
      if (lr_on) cmp(lr_name, bus.dg_bc_dt, lr_val);
    end
  end

  // One cycle: drive inputs, predict, cross the edge, then commit the model.
  task automatic apply(bit r, bit en, bit bk, bit pre, int ia, int ma, bit brev,
                       bit we, logic [RAW-1:0] wa, logic [15:0] wd, logic [RAW-1:0] rda);
    int iv, mv, lv, bv, s, n, addr, wb, wk;
    rst               = r;
    bus.ps_dg_en      = en;
    bus.ps_dg_dgsclt  = bk;
    bus.ps_dg_pre     = pre;
    bus.ps_dg_iadd    = IW'(ia);
    bus.ps_dg_madd    = IW'(ma);
    bus.ps_dg_brev    = brev;
    bus.ps_dg_wrt_en  = we;
    bus.ps_dg_wrt_add = wa;
    bus.ps_dg_rd_add  = rda;
    bus.bc_dt         = wd;
    e_rd = (we && wa == rda) ? wd : 16'(model_rd(rda));
    iv = (we && wa == ra(0, bk, ia)) ? int'(wd) : mi[bk][ia];
    mv = (we && wa == ra(1, bk, ma)) ? int'(wd) : mm[bk][ma];
    lv = (we && wa == ra(2, bk, ia)) ? int'(wd) : ml[bk][ia];
    bv = (we && wa == ra(3, bk, ia)) ? int'(wd) : mb[bk][ia];
    s = iv + ((mv >= 32768) ? mv - 65536 : mv);
    if (lv != 0) begin
      if (s >= bv + lv) s = s - lv;
      else if (s < bv) s = s + lv;
    end
    n = (s + 262144) % 65536;
    addr = pre ? n : iv;
`ifdef DAG_BITREV_EN
    if (brev && !pre) addr = bitrev16(iv);
`endif
    @(posedge clk);
    #1;
    la_on = 1'b0;
    lr_on = 1'b0;
    if (r) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < NREG; k++) begin
          mi[b][k] = 0; mm[b][k] = 0; ml[b][k] = 0; mb[b][k] = 0;
        end
      end
      e_dm_add = '0; e_ps_add = '0; e_dm_vld = 1'b0; e_ps_vld = 1'b0;
    end else begin
      if (en && !pre) mi[bk][ia] = n;
      if (we) begin
        wb = int'(wa[3]);
        wk = int'(wa[2:0]);
        case (wa[5:4])
          2'd0: mi[wb][wk] = int'(wd);
          2'd1: mm[wb][wk] = int'(wd);
          2'd2: ml[wb][wk] = int'(wd);
          default: begin
            mb[wb][wk] = int'(wd);
            mi[wb][wk] = int'(wd);
          end
        endcase
      end
      e_dm_vld = 1'b0;
      e_ps_vld = 1'b0;
      if (en) begin
        if (bk) begin
          e_ps_add = 16'(addr); e_ps_vld = 1'b1;
        end else begin
          e_dm_add = 16'(addr); e_dm_vld = 1'b1;
        end
      end
    end
  endtask

  task automatic wr(logic [RAW-1:0] a, logic [15:0] d);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, a, d, a);
  endtask

  task automatic rdr(logic [RAW-1:0] a);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, '0, '0, a);
  endtask

  task automatic acc(bit bk, bit pre, int ia, int ma, bit brev);
    apply(1'b0, 1'b1, bk, pre, ia, ma, brev, 1'b0, '0, '0, '0);
  endtask

  task automatic lit_addr(bit ps, logic [15:0] v, string nm);
    la_on = 1'b1; la_ps = ps; la_val = v; la_name = nm;
  endtask

  task automatic lit_rd(logic [15:0] v, string nm);
    lr_on = 1'b1; lr_val = v; lr_name = nm;
  endtask

  initial begin
    apply(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, '0, '0, '0);
    chk_en = 1'b1;
    for (int a = 0; a < 64; a++) begin
      if (a % 9 == 0) lit_rd(16'h0000, "reset_reg");
      rdr(RAW'(a));
    end

    // Linear post-modify on bank 0
    wr(ra(0, 0, 0), 16'h0100);
    wr(ra(1, 0, 1), 16'h0004);
    acc(1'b0, 1'b0, 0, 1, 1'b0); lit_addr(1'b0, 16'h0100, "lin_a0");
    acc(1'b0, 1'b0, 0, 1, 1'b0); lit_addr(1'b0, 16'h0104, "lin_a1");
    acc(1'b0, 1'b0, 0, 1, 1'b0); lit_addr(1'b0, 16'h0108, "lin_a2");
    lit_rd(16'h010C, "lin_i0");
    rdr(ra(0, 0, 0));

    // Circular buffer on bank 1
    wr(ra(3, 1, 2), 16'h0200);
    wr(ra(2, 1, 2), 16'h0005);
    wr(ra(1, 1, 3), 16'h0002);
    for (int k = 0; k < 5; k++) begin
      acc(1'b1, 1'b0, 2, 3, 1'b0);
      lit_addr(1'b1, circ_exp[k], "circ_a");
    end
    wr(ra(1, 1, 3), 16'hFFFD);
    wr(ra(3, 1, 2), 16'h0200);
    acc(1'b1, 1'b0, 2, 3, 1'b0); lit_addr(1'b1, 16'h0200, "circ_neg_a");
    lit_rd(16'h0202, "circ_neg_i2");
    rdr(ra(0, 1, 2));

    // Pre-modify leaves I untouched
    wr(ra(0, 0, 0), 16'h0010);
    wr(ra(1, 0, 0), 16'hFFFF);
    acc(1'b0, 1'b1, 0, 0, 1'b0); lit_addr(1'b0, 16'h000F, "pre_a");
    lit_rd(16'h0010, "pre_i0");
    rdr(ra(0, 0, 0));

    // Same-cycle I write plus post-modify access: bypass and write wins
    wr(ra(1, 0, 1), 16'h0001);
    lit_rd(16'h0050, "wthru_rd");
    apply(1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 1'b1, ra(0, 0, 0), 16'h0050, ra(0, 0, 0));
    lit_addr(1'b0, 16'h0050, "coll_a");
    lit_rd(16'h0050, "coll_i0");
    rdr(ra(0, 0, 0));

    // Bit-reverse request on post-modify
    wr(ra(0, 0, 0), 16'h0001);
    acc(1'b0, 1'b0, 0, 1, 1'b1); lit_addr(1'b0, BrevExp, "brev_a");
    lit_rd(16'h0002, "brev_i0");
    rdr(ra(0, 0, 0));

    // Same-cycle M bypass on a pre-modify PM access
    apply(1'b0, 1'b1, 1'b1, 1'b1, 2, 3, 1'b0, 1'b1, ra(1, 1, 3), 16'h0001, ra(1, 1, 3));

    // Mixed directed pattern: interleaved banks, modes and writes
    for (int i = 0; i < 24; i++) begin
      apply(1'b0, (i % 4) != 3, (i % 2) == 1, ((i / 2) % 2) == 1, i % 4, (i + 1) % 4,
            (i % 5) == 0, (i % 3) == 0, RAW'((i * 7) % 64), 16'(i * 37 + 3),
            RAW'((i * 5) % 64));
    end

    // Reset overrides a same-cycle write and access
    apply(1'b1, 1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 1'b1, ra(0, 0, 0), 16'hABCD, ra(0, 0, 0));
    lit_rd(16'h0000, "rst_ovr_i0");
    rdr(ra(0, 0, 0));
    rdr(ra(3, 1, 2));

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
